alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder; consumes its 4-bit aluControl code.
- Add, xor and sub complete in one cycle. Sll uses a serial shifter, one bit per cycle, to save area.
- A start/busy/done handshake lets the multi-cycle control FSM stall the datapath until the result is valid.
- The zero flag feeds the bne branch decision.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; taken from b[SHAMT_W-1:0]

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
aluControl  input  4  operation code from ALU control decoder
a  input  WIDTH  operand A (rs1)
b  input  WIDTH  operand B (rs2 or immediate)
result  output  WIDTH  registered result; held until the next accepted start
zero  output  1  high when result == 0 (combinational from the result register)
busy  output  1  high while a shift is in progress
done  output  1  one-cycle pulse; result is valid
illegal  output  1  registered; set on an unsupported code, cleared on the next accepted start

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on the clk edge with reset=1:
  - state=IDLE; result=0, busy=0, done=0, illegal=0; therefore zero=1.
  - Internal shift register and counter cleared.
  - Reset has priority over start and over an in-progress shift; the aborted shift produces no done.
- States:
  - IDLE: accepts start.
  - SHIFT: serial sll in progress; busy=1.
- done defaults to 0 every cycle unless set as described below.
- Start accepted at edge k (state IDLE, start=1), by decoded aluControl:
  - 4'b0010 add: result<=a+b, modulo 2^WIDTH, carry discarded.
  - 4'b0011 xor: result<=a^b.
  - 4'b0110 sub: result<=a-b, two's complement wrap.
  - For all three: done=1 during cycle k+1; state stays IDLE.
  - 4'b0100 sll with n=b[SHAMT_W-1:0]:
    - n=0: result<=a, done in cycle k+1, no SHIFT state.
    - n>0: shreg<=a, cnt<=n, state<=SHIFT, busy=1 from cycle k+1.
  - Any other code: result<=0, illegal<=1, done in cycle k+1.
  - illegal<=0 for every supported code.
- SHIFT state, each edge:
  - shreg<=shreg<<1; cnt<=cnt-1.
  - On the edge where cnt==1: result<=shreg<<1, done<=1, busy<=0, state<=IDLE.
  - Net: done is high in cycle k+n+1; total latency is n+1 cycles; busy is high for exactly n cycles.
  - b[WIDTH-1:SHAMT_W] is ignored; bits shifted out are lost.
- Inputs a, b and aluControl are captured only at acceptance; changes during SHIFT have no effect.
- start while busy=1 is ignored, not queued.
- start in the same cycle that done is high is accepted; back-to-back single-cycle ops give done every cycle.
- result and illegal keep their values while idle and through ignored starts.

Test Plan:
1. Reset mid-flow: assert reset with start=1 and aluControl=0010 -> next cycle result=0, zero=1, done=0, busy=0, illegal=0.
2. Back-to-back single-cycle ops, start held high:
   - add a=0xFFFFFFFF, b=1 -> result=0x00000000, zero=1, done the next cycle.
   - then xor a=0xF0F0F0F0, b=0xFFFF0000 -> result=0x0F0FF0F0, zero=0, done on consecutive cycles.
3. sub a=5, b=5 -> result=0, zero=1 (bne not taken). Then sub a=3, b=5 -> result=0xFFFFFFFE, zero=0.
4. sll a=0x00000001, b=0x00000023 (n=3):
   - busy high exactly 3 cycles; done in cycle k+4; result=0x00000008.
   - start and changed operands pulsed during busy are ignored.
   - sll with n=0 -> result=a after 1 cycle.
   - sll with n=31, a=0x3 -> result=0x80000000 after 32 cycles.
5. Unsupported code 4'b1111 -> result=0, illegal=1, done after 1 cycle; the next add clears illegal.
6. sll a=1, n=10; assert reset after 4 busy cycles -> busy=0 and result=0 next cycle; no done pulse.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: add/xor/sub finish in one cycle; sll uses a serial shifter, one bit per cycle.
// A start/busy/done handshake lets the control FSM stall until the result is valid.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    illegal_d = 1'b0;
                    case (aluControl)
                        OP_ADD: begin
                            result_d = a + b;
                            done_d   = 1'b1;
                        end
                        OP_XOR: begin
                            result_d = a ^ b;
                            done_d   = 1'b1;
                        end
                        OP_SUB: begin
                            result_d = a - b;
                            done_d   = 1'b1;
                        end
                        OP_SLL: begin
                            // A zero shift amount completes immediately without entering SHIFT.
                            if (shamt == '0) begin
                                result_d = a;
                                done_d   = 1'b1;
                            end else begin
                                shreg_d = a;
                                cnt_d   = shamt;
                                busy_d  = 1'b1;
                                state_d = SHIFT;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - SHAMT_W'(1);
                // Final step: publish the last shifted value directly rather than waiting a cycle.
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shreg_q << 1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = (result_q == '0);
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: latency/result model compared every cycle, plus directed literal checks.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  aluControl = 4'b0000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        zero, busy, done, illegal;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .aluControl(aluControl),
        .a(a), .b(b), .result(result), .zero(zero), .busy(busy),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Model: tracks what the outputs must be, counting down remaining shift cycles.
    logic [31:0] m_result = '0, m_pending = '0;
    logic        m_illegal = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_result = '0; m_illegal = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_done) m_result = m_pending;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_illegal = 1'b0;
                case (aluControl)
                    4'b0010: begin m_result = a + b; m_done = 1'b1; end
                    4'b0011: begin m_result = a ^ b; m_done = 1'b1; end
                    4'b0110: begin m_result = a - b; m_done = 1'b1; end
                    4'b0100: begin
                        if (b % 32 == 0) begin
                            m_result = a; m_done = 1'b1;
                        end else begin
                            m_pending = a << (b % 32);
                            m_left = int'(b % 32);
                        end
                    end
                    default: begin m_result = 0; m_illegal = 1'b1; m_done = 1'b1; end
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.result", result, m_result);
            chk("model.zero", {31'b0, zero}, {31'b0, m_result == 0});
            chk("model.busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("model.done", {31'b0, done}, {31'b0, m_done});
            chk("model.illegal", {31'b0, illegal}, {31'b0, m_illegal});
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; aluControl = op; a = av; b = bv;
    endtask

    // Present one request for a single edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        drive(op, av, bv);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Bounded wait for done; optionally pokes a start with new operands while busy.
    task automatic wait_done(input int budget, input bit poke, output int cycles, output int busy_cnt);
        cycles = 0; busy_cnt = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (poke && cycles == 1) drive(4'b0010, 32'hFFFF_FFFF, 32'h5);
            if (poke && cycles == 2) start = 1'b0;
        end while (!done && cycles < budget);
        if (!done) chk("wait_done.timeout", 32'(cycles), 32'(budget + 1));
    endtask

    int cyc, bcnt, dones;

    initial begin
        @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset mid-flow with start asserted.
        issue(4'b0010, 32'd1, 32'd2);
        @(negedge clk); chk("pre_reset.result", result, 32'd3);
        reset = 1'b1; drive(4'b0010, 32'd7, 32'd9);
        @(posedge clk); #2; reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset.result", result, 32'h0);
        chk("reset.zero", {31'b0, zero}, 32'd1);
        chk("reset.done", {31'b0, done}, 32'd0);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.illegal", {31'b0, illegal}, 32'd0);

        // Back-to-back add then xor with start held.
        @(posedge clk); #2;
        drive(4'b0010, 32'hFFFF_FFFF, 32'h1);
        @(posedge clk); #2;
        drive(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000);
        @(negedge clk);
        chk("add.result", result, 32'h0);
        chk("add.zero", {31'b0, zero}, 32'd1);
        chk("add.done", {31'b0, done}, 32'd1);
        @(posedge clk); #2; start = 1'b0;
        @(negedge clk);
        chk("xor.result", result, 32'h0F0F_F0F0);
        chk("xor.zero", {31'b0, zero}, 32'd0);
        chk("xor.done", {31'b0, done}, 32'd1);

        // Sub equal and wrap.
        issue(4'b0110, 32'd5, 32'd5);
        @(negedge clk); chk("sub_eq.result", result, 32'h0); chk("sub_eq.zero", {31'b0, zero}, 32'd1);
        issue(4'b0110, 32'd3, 32'd5);
        @(negedge clk); chk("sub_wrap.result", result, 32'hFFFF_FFFE); chk("sub_wrap.zero", {31'b0, zero}, 32'd0);

        // sll n=3 with an ignored start during busy.
        issue(4'b0100, 32'h1, 32'h23);
        wait_done(40, 1'b1, cyc, bcnt);
        chk("sll3.latency", 32'(cyc), 32'd4);
        chk("sll3.busy_cycles", 32'(bcnt), 32'd3);
        chk("sll3.result", result, 32'h8);
        @(negedge clk); chk("sll3.held", result, 32'h8);

        issue(4'b0100, 32'hDEAD_BEEF, 32'h40);
        wait_done(40, 1'b0, cyc, bcnt);
        chk("sll0.latency", 32'(cyc), 32'd1);
        chk("sll0.result", result, 32'hDEAD_BEEF);

        issue(4'b0100, 32'h3, 32'd31);
        wait_done(40, 1'b0, cyc, bcnt);
        chk("sll31.latency", 32'(cyc), 32'd32);
        chk("sll31.busy_cycles", 32'(bcnt), 32'd31);
        chk("sll31.result", result, 32'h8000_0000);

        // Unsupported code, then an add clears illegal.
        issue(4'b1111, 32'h1234, 32'h5678);
        @(negedge clk);
        chk("illegal.result", result, 32'h0);
        chk("illegal.flag", {31'b0, illegal}, 32'd1);
        chk("illegal.done", {31'b0, done}, 32'd1);
        issue(4'b0010, 32'd10, 32'd20);
        @(negedge clk);
        chk("clear.illegal", {31'b0, illegal}, 32'd0);
        chk("clear.result", result, 32'd30);

        // Reset aborts a shift; no done afterwards.
        issue(4'b0100, 32'h1, 32'd10);
        repeat (4) @(negedge clk);
        chk("abort.busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk);
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.result", result, 32'h0);
        dones = 0;
        repeat (12) begin @(negedge clk); if (done) dones++; end
        chk("abort.no_done", 32'(dones), 32'd0);

        // Randomized traffic against the model.
        repeat (600) begin
            @(posedge clk); #2;
            reset = ($urandom_range(0, 59) == 0);
            start = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: aluControl = 4'b0010;
                1: aluControl = 4'b0011;
                2: aluControl = 4'b0110;
                3, 4: aluControl = 4'b0100;
                default: aluControl = 4'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
        end
        @(posedge clk); #2; reset = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
